// File: rtl/rw_4x4_ctrl.sv
// rw_4x4_ctrl
// Sequences single-word reads and writes to a 4-word x 4-bit asynchronous RAM
// on behalf of a valid/ready requester.
//
// Write timing: address and data are set up for one cycle with WE low.
// WE is then pulsed for WR_PULSE cycles. Address and data are held for one
// more cycle with WE low. No response is returned for a write.
//
// Read timing: address is set up for one cycle. The RAM output settles for
// RD_WAIT cycles. The data is then captured and presented on the response
// channel until it is taken.
//
// Every output is a flop, so no input reaches an output combinationally.
//
// Ports:
//   clk          - clock, rising edge active
//   rst_n        - asynchronous active-low reset
//   req_valid    - requester presents an access
//   req_ready    - controller is idle and can accept an access
//   req_we       - 1 = write, 0 = read
//   req_addr     - word address
//   req_wdata    - write data
//   rsp_valid    - read data is available
//   rsp_ready    - requester takes the read data
//   rsp_rdata    - read data
//   mem_address  - RAM address
//   mem_we       - RAM write enable
//   mem_data_in  - RAM write data
//   mem_data_out - RAM read data
module rw_4x4_ctrl #(
  parameter int unsigned WR_PULSE = 1,
  parameter int unsigned RD_WAIT  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [1:0] req_addr,
  input  logic [3:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_rdata,
  output logic [1:0] mem_address,
  output logic       mem_we,
  output logic [3:0] mem_data_in,
  input  logic [3:0] mem_data_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    WAIT  = 3'd4,
    RESP  = 3'd5
  } state_t;

  // Each counter is loaded with "cycles - 1" and the state is left when it reaches zero.
  localparam logic [3:0] PULSE_LAST = 4'(WR_PULSE - 1);
  localparam logic [3:0] WAIT_LAST  = 4'(RD_WAIT - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic [3:0] cnt_next;
  logic       is_write;
  logic       is_write_next;
  logic [1:0] addr_next;
  logic [3:0] wdata_next;
  logic [3:0] rdata_next;
  logic       ready_next;
  logic       we_next;
  logic       valid_next;

  // Next-state, datapath and output decode. The outputs are derived from the
  // next state so that the registered outputs line up with the state they describe.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    is_write_next = is_write;
    addr_next     = mem_address;
    wdata_next    = mem_data_in;
    rdata_next    = rsp_rdata;

    case (state)
      IDLE: begin
        // req_ready is a flop that is 1 only while in IDLE, and it is 0 in the first cycle after reset.
        if (req_valid && req_ready) begin
          state_next    = SETUP;
          is_write_next = req_we;
          addr_next     = req_addr;
          wdata_next    = req_wdata;
        end else begin
          state_next = IDLE;
        end
      end
      SETUP: begin
        if (is_write) begin
          state_next = PULSE;
          cnt_next   = PULSE_LAST;
        end else begin
          state_next = WAIT;
          cnt_next   = WAIT_LAST;
        end
      end
      PULSE: begin
        if (cnt == 4'd0) begin
          state_next = HOLD;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      HOLD: begin
        state_next = IDLE;
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_next = RESP;
          rdata_next = mem_data_out;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end else begin
          state_next = RESP;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    ready_next = (state_next == IDLE);
    we_next    = (state_next == PULSE);
    valid_next = (state_next == RESP);
  end

  // State, counter, latched request and registered outputs.
  // Reset clears all of them asynchronously, which forces WE low at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      is_write    <= 1'b0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 4'd0;
      mem_we      <= 1'b0;
      mem_address <= 2'd0;
      mem_data_in <= 4'd0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      is_write    <= is_write_next;
      req_ready   <= ready_next;
      rsp_valid   <= valid_next;
      rsp_rdata   <= rdata_next;
      mem_we      <= we_next;
      mem_address <= addr_next;
      mem_data_in <= wdata_next;
    end
  end

endmodule

// File: tb/tb_rw_4x4_ctrl.sv
// Self-checking bench for rw_4x4_ctrl.
// It runs three instances, each with its own behavioural 4x4 RAM:
//   instance 0: WR_PULSE=1, RD_WAIT=1
//   instance 1: WR_PULSE=4, RD_WAIT=1
//   instance 2: WR_PULSE=3, RD_WAIT=2
module tb_rw_4x4_ctrl;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n        [N];
  logic       req_valid    [N];
  logic       req_ready    [N];
  logic       req_we       [N];
  logic [1:0] req_addr     [N];
  logic [3:0] req_wdata    [N];
  logic       rsp_valid    [N];
  logic       rsp_ready    [N];
  logic [3:0] rsp_rdata    [N];
  logic [1:0] mem_address  [N];
  logic       mem_we       [N];
  logic [3:0] mem_data_in  [N];
  logic [3:0] mem_data_out [N];

  logic [3:0] ram     [N][4];
  logic [3:0] exp_mem [N][4];
  logic [1:0] prev_addr [N];
  logic [3:0] prev_din  [N];
  int         we_viol = 0;
  logic [3:0] sb_q[$];

  int n_pass  = 0;
  int n_total = 0;

  function automatic int wp_of(input int i);
    case (i)
      0:       return 1;
      1:       return 4;
      default: return 3;
    endcase
  endfunction

  function automatic int rw_of(input int i);
    case (i)
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int WP = (g == 0) ? 1 : ((g == 1) ? 4 : 3);
    localparam int RW = (g == 2) ? 2 : 1;
    rw_4x4_ctrl #(.WR_PULSE(WP), .RD_WAIT(RW)) dut (
      .clk          (clk),
      .rst_n        (rst_n[g]),
      .req_valid    (req_valid[g]),
      .req_ready    (req_ready[g]),
      .req_we       (req_we[g]),
      .req_addr     (req_addr[g]),
      .req_wdata    (req_wdata[g]),
      .rsp_valid    (rsp_valid[g]),
      .rsp_ready    (rsp_ready[g]),
      .rsp_rdata    (rsp_rdata[g]),
      .mem_address  (mem_address[g]),
      .mem_we       (mem_we[g]),
      .mem_data_in  (mem_data_in[g]),
      .mem_data_out (mem_data_out[g])
    );
    assign mem_data_out[g] = ram[g][mem_address[g]];
  end

  // RAM write, sampled mid-cycle. This block also flags WE being high while
  // the RAM address or data changed since the previous cycle.
  always @(negedge clk) begin
    int v;
    v = 0;
    for (int i = 0; i < N; i++) begin
      if (mem_we[i] === 1'b1) begin
        if (mem_address[i] !== prev_addr[i] || mem_data_in[i] !== prev_din[i]) v = v + 1;
        ram[i][mem_address[i]] <= mem_data_in[i];
      end
      prev_addr[i] <= mem_address[i];
      prev_din[i]  <= mem_data_in[i];
    end
    we_viol <= we_viol + v;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write with full timing check; returns in the first IDLE cycle.
  task automatic do_write(input int i, input logic [1:0] a, input logic [3:0] d, input string tag);
    int wp;
    wp = wp_of(i);
    check({tag, "_rdy_pre"}, 32'(req_ready[i]), 32'd1);
    req_valid[i] = 1'b1; req_we[i] = 1'b1; req_addr[i] = a; req_wdata[i] = d;
    tick();  // acceptance edge
    req_valid[i] = 1'b0; req_we[i] = 1'b0;
    req_addr[i] = 2'($urandom); req_wdata[i] = 4'($urandom);
    check({tag, "_setup_we"}, 32'(mem_we[i]), 32'd0);
    check({tag, "_setup_rdy"}, 32'(req_ready[i]), 32'd0);
    check({tag, "_setup_addr"}, 32'(mem_address[i]), 32'(a));
    check({tag, "_setup_din"}, 32'(mem_data_in[i]), 32'(d));
    for (int k = 0; k < wp; k++) begin
      tick();
      check({tag, "_pulse_we"}, 32'(mem_we[i]), 32'd1);
      check({tag, "_pulse_addr"}, 32'(mem_address[i]), 32'(a));
    end
    tick();
    check({tag, "_hold_we"}, 32'(mem_we[i]), 32'd0);
    check({tag, "_hold_rdy"}, 32'(req_ready[i]), 32'd0);
    tick();
    check({tag, "_idle_rdy"}, 32'(req_ready[i]), 32'd1);
    check({tag, "_idle_addr"}, 32'(mem_address[i]), 32'(a));
    check({tag, "_idle_din"}, 32'(mem_data_in[i]), 32'(d));
    exp_mem[i][a] = d;
  endtask

  // Read. If rsp_ready is high, the task also consumes the response.
  // Otherwise it returns in the first RESP cycle.
  task automatic do_read(input int i, input logic [1:0] a, input string tag);
    int lat;
    logic we_seen;
    logic [3:0] e;
    check({tag, "_rdy_pre"}, 32'(req_ready[i]), 32'd1);
    sb_q.push_back(exp_mem[i][a]);
    req_valid[i] = 1'b1; req_we[i] = 1'b0; req_addr[i] = a; req_wdata[i] = 4'($urandom);
    tick();
    req_valid[i] = 1'b0; req_addr[i] = 2'($urandom);
    check({tag, "_acc_rdy"}, 32'(req_ready[i]), 32'd0);
    lat = 0;
    we_seen = mem_we[i];
    while (rsp_valid[i] !== 1'b1 && lat < 40) begin
      tick();
      lat++;
      we_seen = we_seen | mem_we[i];
    end
    check({tag, "_latency"}, 32'(lat), 32'(1 + rw_of(i)));
    check({tag, "_no_we"}, 32'(we_seen), 32'd0);
    e = sb_q.pop_front();
    check({tag, "_rdata"}, 32'(rsp_rdata[i]), 32'(e));
    if (rsp_ready[i] === 1'b1) begin
      tick();
      check({tag, "_rsp_clr"}, 32'(rsp_valid[i]), 32'd0);
      check({tag, "_rdy_back"}, 32'(req_ready[i]), 32'd1);
      check({tag, "_rdata_keep"}, 32'(rsp_rdata[i]), 32'(e));
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0;
      req_addr[i] = 2'd0; req_wdata[i] = 4'd0; rsp_ready[i] = 1'b1;
    end
    tick();
    tick();
    for (int i = 0; i < N; i++) begin
      check("rst_rdy", 32'(req_ready[i]), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
      check("rst_rdata", 32'(rsp_rdata[i]), 32'd0);
      check("rst_we", 32'(mem_we[i]), 32'd0);
      check("rst_addr", 32'(mem_address[i]), 32'd0);
      check("rst_din", 32'(mem_data_in[i]), 32'd0);
      rst_n[i] = 1'b1;
    end
    #1;
    check("rel_rdy_before_edge", 32'(req_ready[0]), 32'd0);
    tick();
    for (int i = 0; i < N; i++) check("rel_rdy_first_edge", 32'(req_ready[i]), 32'd1);

    // Write addr 2 = 0xA, then read it back.
    do_write(0, 2'd2, 4'hA, "w_a2");
    do_read(0, 2'd2, "r_a2");

    // Back-to-back sweep: writes, then reads.
    do_write(0, 2'd0, 4'h1, "sw_w0");
    do_write(0, 2'd1, 4'h2, "sw_w1");
    do_write(0, 2'd2, 4'h4, "sw_w2");
    do_write(0, 2'd3, 4'h8, "sw_w3");
    do_read(0, 2'd0, "sw_r0");
    do_read(0, 2'd1, "sw_r1");
    do_read(0, 2'd2, "sw_r2");
    do_read(0, 2'd3, "sw_r3");

    // Response backpressure, with a stray request pulse that must be ignored.
    rsp_ready[0] = 1'b0;
    do_read(0, 2'd1, "bp");
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 2'd1; req_wdata[0] = 4'hF;
      end else begin
        req_valid[0] = 1'b0; req_we[0] = 1'b0;
      end
      tick();
      check("bp_valid", 32'(rsp_valid[0]), 32'd1);
      check("bp_rdata", 32'(rsp_rdata[0]), 32'h2);
      check("bp_rdy", 32'(req_ready[0]), 32'd0);
      check("bp_we", 32'(mem_we[0]), 32'd0);
    end
    req_valid[0] = 1'b0; req_we[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    tick();
    check("bp_release_valid", 32'(rsp_valid[0]), 32'd0);
    check("bp_release_rdy", 32'(req_ready[0]), 32'd1);
    do_read(0, 2'd1, "bp_after");

    // WR_PULSE=3, RD_WAIT=2 timing.
    do_write(2, 2'd3, 4'h5, "p_w3");
    do_read(2, 2'd3, "p_r3");

    // Reset during PULSE with WR_PULSE=4.
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 2'd1; req_wdata[1] = 4'h6;
    tick();
    req_valid[1] = 1'b0; req_we[1] = 1'b0;
    tick();
    check("mr_pulse_we", 32'(mem_we[1]), 32'd1);
    #2;
    rst_n[1] = 1'b0;
    #1;
    check("mr_async_we", 32'(mem_we[1]), 32'd0);
    check("mr_async_rdy", 32'(req_ready[1]), 32'd0);
    check("mr_async_addr", 32'(mem_address[1]), 32'd0);
    tick();
    tick();
    rst_n[1] = 1'b1;
    check("mr_rdy_in_release", 32'(req_ready[1]), 32'd0);
    tick();
    check("mr_rdy_first_edge", 32'(req_ready[1]), 32'd1);
    for (int k = 0; k < 6; k++) begin
      check("mr_no_rsp", 32'(rsp_valid[1]), 32'd0);
      check("mr_no_we", 32'(mem_we[1]), 32'd0);
      tick();
    end
    do_write(1, 2'd0, 4'h9, "mr_w0");
    do_read(1, 2'd0, "mr_r0");

    tick();
    check("we_while_changing", 32'(we_viol), 32'd0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rw_4x4_ctrl.md
RW_4X4_CTRL -- requirements
Module: rw_4x4_ctrl

Interface
REQ-001 Parameter WR_PULSE, default 1: number of cycles mem_we is held high per write; legal range 1..15.
REQ-002 Parameter RD_WAIT, default 1: number of wait cycles between the read setup and sampling of mem_data_out; legal range 1..15.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port req_valid, input, 1 bit: the requester presents an access.
REQ-006 Port req_ready, output, 1 bit: the controller can accept an access.
REQ-007 Port req_we, input, 1 bit: 1 selects a write, 0 selects a read.
REQ-008 Port req_addr, input, 2 bits: word address.
REQ-009 Port req_wdata, input, 4 bits: write data.
REQ-010 Port rsp_valid, output, 1 bit: read data is available.
REQ-011 Port rsp_ready, input, 1 bit: the requester takes the read data.
REQ-012 Port rsp_rdata, output, 4 bits: read data.
REQ-013 Port mem_address, output, 2 bits: drives the address of the 4x4 asynchronous RAM.
REQ-014 Port mem_we, output, 1 bit: drives WE of the RAM.
REQ-015 Port mem_data_in, output, 4 bits: drives data_in of the RAM.
REQ-016 Port mem_data_out, input, 4 bits: receives data_out of the RAM.

Function
REQ-017 All outputs SHALL come directly from flops; there are no combinational paths from any input to any output.
REQ-018 The FSM SHALL have these states: IDLE, SETUP, PULSE, HOLD, WAIT, RESP.
REQ-019 req_ready SHALL be 1 only in IDLE.
REQ-020 A request SHALL be accepted on an edge where req_valid=1 and req_ready=1.
- At acceptance, req_we, req_addr and req_wdata are latched.
- The FSM then moves to SETUP.
REQ-021 From acceptance until the FSM returns to IDLE, mem_address and mem_data_in SHALL hold the latched values.
- They remain at those values after the return to IDLE.
- They change only at the next acceptance.
REQ-022 The write path SHALL be SETUP (1 cycle, mem_we=0), then PULSE (WR_PULSE cycles, mem_we=1), then HOLD (1 cycle, mem_we=0), then IDLE.
REQ-023 A write SHALL produce no response; req_ready returns to 1 exactly 2+WR_PULSE cycles after acceptance.
REQ-024 The read path SHALL be SETUP (1 cycle), then WAIT (RD_WAIT cycles), with mem_we=0 throughout.
REQ-025 On the edge ending the last WAIT cycle, mem_data_out SHALL be sampled into rsp_rdata and the FSM SHALL enter RESP with rsp_valid=1.
- rsp_valid therefore first rises 1+RD_WAIT cycles after acceptance.
REQ-026 In RESP, rsp_valid and rsp_rdata SHALL hold stable until an edge with rsp_ready=1.
- On that edge, rsp_valid clears and the FSM enters IDLE.
REQ-027 rsp_rdata SHALL keep its last value outside RESP.
REQ-028 req_valid SHALL be ignored outside IDLE; no request is queued.
REQ-029 mem_we SHALL never be 1 on any cycle in which mem_address or mem_data_in differs from the value it had on the previous cycle.
REQ-030 Back-to-back accesses SHALL be supported with exactly one IDLE cycle between them.

Reset
REQ-031 While rst_n=0, the controller SHALL hold the following values:
- state IDLE
- req_ready=0
- rsp_valid=0
- rsp_rdata=0
- mem_we=0
- mem_address=0
- mem_data_in=0
REQ-032 req_ready SHALL become 1 on the first rising clk edge after rst_n deasserts.
REQ-033 Reset asserted mid-access SHALL immediately force mem_we=0 and SHALL discard the access with no response.

Verification
REQ-034 Write scenario, WR_PULSE=1: write addr 2, data 0xA accepted at edge E0 -> mem_we=1 only between E1 and E2, and req_ready=1 again after E3.
REQ-035 Read-back scenario, RD_WAIT=1: after the write of REQ-034, read addr 2 with rsp_ready=1 -> rsp_valid=1 with rsp_rdata=0xA, 2 cycles after acceptance.
REQ-036 Full sweep: write 0x1, 0x2, 0x4, 0x8 to addresses 0..3 back-to-back, then read all four -> read data matches in order, with one IDLE cycle between accesses.
REQ-037 Response backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata are stable, req_ready=0, and a req_valid pulse is ignored.
REQ-038 Reset during PULSE with WR_PULSE=4 -> mem_we falls asynchronously, no rsp_valid follows, and req_ready=1 on the first edge after release.
REQ-039 Parameter timing: WR_PULSE=3, RD_WAIT=2 -> mem_we is high for exactly 3 cycles, and rsp_valid rises 3 cycles after read acceptance.
